bp_update_scheduler: RTL and testbench

BP_UPDATE_SCHEDULER -- requirements
Module: bp_update_scheduler

---
 rtl/bp_update_scheduler_pkg.sv | 24 ++
 rtl/bp_update_fifo.sv | 90 +++++++++
 rtl/bp_update_scheduler.sv | 179 +++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_scheduler_pkg.sv
// Shared types for the branch-target update scheduler.
//   BTUpdate       : one branch-target update (valid qualifier, source PC, target)
//   BPSchedState_t : scheduler FSM state (CLEAR sweep / RUN)
//   sat_add8       : 8-bit saturating add used by the drop counter
package bp_update_scheduler_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] src;
        logic [31:0] dst;
    } BTUpdate;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } BPSchedState_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Multi-write / single-read update FIFO with flush.
// Up to NUM_IN entries are written per cycle, packed in ascending input order
// starting at the write pointer. The caller only raises as many wr_en_i bits
// as there are free slots (counting the same-cycle read).
// Pointers are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   flush_i         : drop all entries (pointers back to 0)
//   wr_en_i/wr_data_i : per-input write strobes and data
//   rd_en_i         : pop the head (ignored when empty)
//   head_o          : entry at the read pointer
//   empty_o, full_o, count_o : occupancy status
module bp_update_fifo
    import bp_update_scheduler_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic [NUM_IN-1:0]        wr_en_i,
    input  BTUpdate                  wr_data_i [NUM_IN],
    input  logic                     rd_en_i,
    output BTUpdate                  head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    BTUpdate       mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] offs [NUM_IN];
    logic [PW-1:0] n_wr;

    // Slot offset of each write = number of enabled writes below it.
    always_comb begin
        n_wr = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            offs[i] = n_wr;
            if (wr_en_i[i]) begin
                n_wr = n_wr + PW'(1);
            end
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wptr_q + n_wr;
            if (rd_en_i && !empty_o) begin
                rptr_d = rptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush_i) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (wr_en_i[i]) begin
                    mem_q[AW'(wptr_q + offs[i])] <= wr_data_i[i];
                end
            end
        end
    end

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign count_o = wptr_q - rptr_q;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/bp_update_scheduler.sv
// Branch-target update scheduler: queues BTB target updates from NUM_IN branch
// units, presents them one at a time to the BTB in FIFO order, and runs a
// full-table clear sweep after reset or on an icache clear request.
// Optional build macro: BPSCHED_FIFO_BYPASS_EN (same-cycle forward of the
// lowest-index valid update when the FIFO is empty and the BTB is ready).
// Ports:
//   clk, rst         : clock, synchronous active-low reset
//   IN_clearICache   : start (or restart) a clear sweep, discarding queued updates
//   IN_btUpdates     : per-requester updates
//   IN_btbReady      : BTB accepts an update or clear write this cycle
//   OUT_btUpdate     : update to the BTB (.valid qualifies)
//   OUT_clrValid/OUT_clrIdx : clear-write strobe and index
//   OUT_stall        : fetch stall while clearing
//   OUT_dropCnt      : saturating count of updates lost to a full FIFO
//   OUT_busy         : clear active or FIFO non-empty
//
// state | meaning
// CLEAR | sweeping BTB indices 0..NUM_IDX-1, updates ignored, fetch stalled
// RUN   | accepting updates and draining the FIFO to the BTB
module bp_update_scheduler
    import bp_update_scheduler_pkg::*;
#(
    parameter int NUM_IN  = 2,
    parameter int DEPTH   = 4,
    parameter int NUM_IDX = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        IN_clearICache,
    input  BTUpdate                     IN_btUpdates [NUM_IN],
    input  logic                        IN_btbReady,
    output BTUpdate                     OUT_btUpdate,
    output logic                        OUT_clrValid,
    output logic [$clog2(NUM_IDX)-1:0]  OUT_clrIdx,
    output logic                        OUT_stall,
    output logic [7:0]                  OUT_dropCnt,
    output logic                        OUT_busy
);

    localparam int IW = $clog2(NUM_IDX);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_IDX - 1);

    BPSchedState_t state_q, state_d;
    logic [IW-1:0] clr_idx_q, clr_idx_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    BTUpdate       fifo_head;
    logic          fifo_empty, fifo_full;
    logic [PW-1:0] fifo_count;
    logic [NUM_IN-1:0] wr_en;
    logic [NUM_IN-1:0] byp_sel;
    logic          deq, flush;
    logic [PW-1:0] free_slots, n_acc;
    logic [7:0]    n_drop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= CLEAR;
            clr_idx_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                if (IN_clearICache) begin
                    clr_idx_d = '0;
                end else if (IN_btbReady) begin
                    if (clr_idx_q == IDX_LAST) begin
                        state_d   = RUN;
                        clr_idx_d = '0;
                    end else begin
                        clr_idx_d = clr_idx_q + IW'(1);
                    end
                end
            end
            RUN: begin
                if (IN_clearICache) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    assign deq   = (state_q == RUN) && !fifo_empty && IN_btbReady;
    assign flush = (state_q == RUN) && IN_clearICache;

`ifdef BPSCHED_FIFO_BYPASS_EN
    BTUpdate byp_upd;
    logic    byp_hit;

    always_comb begin
        byp_sel = '0;
        byp_hit = 1'b0;
        byp_upd = '0;
        if (rst && (state_q == RUN) && !IN_clearICache && fifo_empty && IN_btbReady) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (IN_btUpdates[i].valid && !byp_hit) begin
                    byp_hit    = 1'b1;
                    byp_sel[i] = 1'b1;
                    byp_upd    = IN_btUpdates[i];
                end
            end
        end
    end
`else
    assign byp_sel = '0;
`endif

    // Free slots include the head leaving this cycle, so a full FIFO being
    // drained still takes one new entry. Lowest requester indices win.
    always_comb begin
        wr_en      = '0;
        n_acc      = '0;
        n_drop     = '0;
        free_slots = fifo_full ? PW'(deq) : (PW'(DEPTH) - fifo_count + PW'(deq));
        if ((state_q == RUN) && !IN_clearICache) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (IN_btUpdates[i].valid && !byp_sel[i]) begin
                    if (n_acc < free_slots) begin
                        wr_en[i] = 1'b1;
                        n_acc    = n_acc + PW'(1);
                    end else begin
                        n_drop = n_drop + 8'd1;
                    end
                end
            end
        end
        drop_cnt_d = sat_add8(drop_cnt_q, n_drop);
    end

    bp_update_fifo #(
        .NUM_IN (NUM_IN),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .wr_en_i   (wr_en),
        .wr_data_i (IN_btUpdates),
        .rd_en_i   (deq),
        .head_o    (fifo_head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    // While rst is low the safe values are forced so the fetch side sees a
    // stall even before the first reset edge has landed.
    always_comb begin
        OUT_clrValid       = (state_q == CLEAR) || !rst;
        OUT_stall          = (state_q == CLEAR) || !rst;
        OUT_busy           = (state_q == CLEAR) || !fifo_empty || !rst;
        OUT_clrIdx         = clr_idx_q;
        OUT_dropCnt        = drop_cnt_q;
        OUT_btUpdate       = fifo_head;
        OUT_btUpdate.valid = rst && (state_q == RUN) && !fifo_empty;
`ifdef BPSCHED_FIFO_BYPASS_EN
        if (byp_hit) begin
            OUT_btUpdate       = byp_upd;
            OUT_btUpdate.valid = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_bp_update_scheduler.sv
`timescale 1ns/1ps
module tb_bp_update_scheduler;
    import bp_update_scheduler_pkg::*;

    localparam int NUM_IN  = 2;
    localparam int DEPTH   = 4;
    localparam int NUM_IDX = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       rdy = 1'b0;
    BTUpdate    bt_in [NUM_IN];
    BTUpdate    bt_out;
    logic       clr_valid;
    logic [3:0] clr_idx;
    logic       stall;
    logic [7:0] drop_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    BPSchedState_t m_state = CLEAR;
    int            m_idx   = 0;
    int            m_drop  = 0;
    BTUpdate       m_q [$];
    bit            m_known = 1'b0;

    typedef struct {
        logic        rdy, clr, v0, v1;
        logic        e_valid;
        logic [31:0] e_dst;
        logic [7:0]  e_drop;
        logic        e_busy, e_stall;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    bp_update_scheduler #(
        .NUM_IN  (NUM_IN),
        .DEPTH   (DEPTH),
        .NUM_IDX (NUM_IDX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .IN_clearICache (clr),
        .IN_btUpdates   (bt_in),
        .IN_btbReady    (rdy),
        .OUT_btUpdate   (bt_out),
        .OUT_clrValid   (clr_valid),
        .OUT_clrIdx     (clr_idx),
        .OUT_stall      (stall),
        .OUT_dropCnt    (drop_cnt),
        .OUT_busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic v0, input logic v1,
                         input logic [31:0] d0, input logic [31:0] d1);
        rdy = r;
        clr = c;
        bt_in[0].valid = v0;
        bt_in[0].dst   = d0;
        bt_in[0].src   = d0 ^ 32'hA5A5_0000;
        bt_in[1].valid = v1;
        bt_in[1].dst   = d1;
        bt_in[1].src   = d1 ^ 32'h5A5A_0000;
    endtask

    // Called at the falling edge: compare outputs with the model, then advance
    // the model across the coming rising edge.
    task automatic model_step();
        if (!rst) begin
            chk("rst_stall", stall, 1);
            chk("rst_clrvalid", clr_valid, 1);
            chk("rst_outvalid", bt_out.valid, 0);
            chk("rst_busy", busy, 1);
        end else if (m_known) begin
            chk("stall", stall, m_state == CLEAR);
            chk("clrvalid", clr_valid, m_state == CLEAR);
            if (m_state == CLEAR) chk("clridx", clr_idx, m_idx);
            chk("dropcnt", drop_cnt, m_drop);
            chk("busy", busy, (m_state == CLEAR) || (m_q.size() > 0));
            chk("outvalid", bt_out.valid, (m_state == RUN) && (m_q.size() > 0));
            if ((m_state == RUN) && (m_q.size() > 0)) begin
                chk("head_dst", bt_out.dst, m_q[0].dst);
                chk("head_src", bt_out.src, m_q[0].src);
            end
        end

        if (!rst) begin
            m_state = CLEAR;
            m_idx   = 0;
            m_drop  = 0;
            m_q.delete();
            m_known = 1'b1;
        end else if (m_known) begin
            if (m_state == CLEAR) begin
                if (clr) m_idx = 0;
                else if (rdy) begin
                    if (m_idx == NUM_IDX - 1) begin
                        m_state = RUN;
                        m_idx   = 0;
                    end else m_idx++;
                end
            end else if (clr) begin
                m_q.delete();
                m_state = CLEAR;
                m_idx   = 0;
            end else begin
                if ((m_q.size() > 0) && rdy) void'(m_q.pop_front());
                for (int i = 0; i < NUM_IN; i++) begin
                    if (bt_in[i].valid) begin
                        if (m_q.size() < DEPTH) m_q.push_back(bt_in[i]);
                        else if (m_drop < 255) m_drop++;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_run;

        //            rdy clr v0 v1  valid dst         drop  busy stall
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   8'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 8'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 8'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   8'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h103, 8'd0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h103, 8'd0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h103, 8'd1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h203, 8'd2, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h203, 8'd3, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   8'd3, 1'b1, 1'b1};

        // Reset, then a full sweep with the BTB always ready.
        drive(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        first_run = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1)  chk("sweep_idx_first", clr_idx, 0);
            if (c == 16) chk("sweep_idx_last", clr_idx, 15);
            if (!stall && first_run < 0) first_run = c;
            model_step();
            @(posedge clk);
            #1;
        end
        chk("sweep_stall_fall_cycle", first_run, 17);
        chk("sweep_dropcnt", drop_cnt, 0);

        // Table: ordering, partial accept, full-with-dequeue, clear with queue.
        for (int k = 0; k < 10; k++) begin
            drive(vecs[k].rdy, vecs[k].clr, vecs[k].v0, vecs[k].v1, 32'h100 + k, 32'h200 + k);
            @(negedge clk);
            chk("tbl_valid", bt_out.valid, vecs[k].e_valid);
            if (vecs[k].e_valid) chk("tbl_dst", bt_out.dst, vecs[k].e_dst);
            chk("tbl_drop", drop_cnt, vecs[k].e_drop);
            chk("tbl_busy", busy, vecs[k].e_busy);
            chk("tbl_stall", stall, vecs[k].e_stall);
            model_step();
            @(posedge clk);
            #1;
        end

        // Clear request mid-sweep restarts at index 0.
        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) cycle();
        chk("sweep_at_5", clr_idx, 5);
        drive(1, 1, 0, 0, 0, 0);
        cycle();
        chk("sweep_restart_0", clr_idx, 0);

        // BTB not ready: the index must hold.
        drive(0, 0, 1, 1, 32'h33, 32'h44);
        cycle();
        cycle();
        chk("sweep_hold", clr_idx, 0);

        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 20; c++) cycle();
        chk("run_reached", stall, 0);

        // Saturate the drop counter with a stalled BTB.
        for (int c = 0; c < 160; c++) begin
            drive(0, 0, 1, 1, 32'h1000 + c, 32'h2000 + c);
            cycle();
        end
        chk("drop_saturated", drop_cnt, 255);

        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 6; c++) cycle();
        chk("drained_idle", busy, 0);

        // Random traffic against the model.
        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom);
            cycle();
        end

        // Reset pulse in the middle of a sweep.
        drive(1, 1, 0, 0, 0, 0);
        cycle();
        drive(1, 0, 1, 1, 32'h77, 32'h88);
        for (int c = 0; c < 20 && m_idx != 9; c++) cycle();
        chk("pre_reset_idx9", clr_idx, 9);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("post_reset_idx0", clr_idx, 0);
        chk("post_reset_drop0", drop_cnt, 0);
        chk("post_reset_stall", stall, 1);
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
